// File: rtl/led16_pkg.sv
// Shared types and constants for the led16 sequencing controller.
package led16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  localparam int SW_CNT_W = 8;

endpackage

// File: rtl/led16_ctl_timer.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module led16_ctl_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/led16_ctl.sv
// Sequencing controller for led16_drv: start/stop, manual or dwell-driven
// mode switching, with an en-low blanking gap around every switch.
module led16_ctl
  import led16_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int GAP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                auto,
  input  logic                mode_req,
  output logic                en,
  output logic                mod,
  output logic [1:0]          state,
  output logic [SW_CNT_W-1:0] sw_cnt
);

  localparam int DW_W  = $clog2(DWELL);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP - 1);

  state_t                state_d, state_q;
  logic                  en_d, en_q;
  logic                  mod_d, mod_q;
  logic [SW_CNT_W-1:0]   sw_cnt_d, sw_cnt_q;
  logic [DW_W-1:0]       dwell_d, dwell_q;

  logic                  gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0]      gap_cnt;

  led16_ctl_timer #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .cnt      (gap_cnt),
    .zero     (gap_zero)
  );

  always_comb begin
    state_d  = state_q;
    mod_d    = mod_q;
    sw_cnt_d = sw_cnt_q;
    dwell_d  = dwell_q;
    gap_load = 1'b0;
    gap_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start wins over mode_req so mod never flips as en rises
        if (!stop) begin
          if (start) begin
            state_d = ST_RUN;
            dwell_d = '0;
          end else if (mode_req) begin
            mod_d = ~mod_q;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (mode_req || (auto && (dwell_q == DWELL_MAX))) begin
          state_d  = ST_SWITCH;
          mod_d    = ~mod_q;
          gap_load = 1'b1;
        end else if (dwell_q != DWELL_MAX) begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_SWITCH: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (gap_zero) begin
          state_d  = ST_RUN;
          dwell_d  = '0;
          sw_cnt_d = sw_cnt_q + 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    en_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mod_q    <= 1'b0;
      sw_cnt_q <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mod_q    <= mod_d;
      sw_cnt_q <= sw_cnt_d;
      dwell_q  <= dwell_d;
    end
  end

  assign en     = en_q;
  assign mod    = mod_q;
  assign state  = state_q;
  assign sw_cnt = sw_cnt_q;

endmodule
